// File: rtl/alu_req_driver_if.sv
// Command, ALU-facing and response signals of alu_req_driver, bundled with master/slave views.
// ALU_DRV_CHAIN_EN adds cmd_chain for result chaining.
interface alu_req_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [4:0]  cmd_shamt;
    logic [3:0]  cmd_tag;
`ifdef ALU_DRV_CHAIN_EN
    logic        cmd_chain;
`endif
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_input1;
    logic [7:0]  alu_input2;
    logic [4:0]  alu_shiftValue;
    logic [7:0]  alu_result;
    logic        alu_carryFlag;
    logic        alu_zeroFlag;
    logic        alu_overFlowFlag;
    logic        alu_signFlag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [3:0]  rsp_tag;
    logic [15:0] op_count;

    modport master (
`ifdef ALU_DRV_CHAIN_EN
        output cmd_chain,
`endif
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag,
        input  cmd_ready,
        input  alu_opcode, alu_input1, alu_input2, alu_shiftValue,
        output alu_result, alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_tag, op_count,
        output rsp_ready
    );

    modport slave (
`ifdef ALU_DRV_CHAIN_EN
        input  cmd_chain,
`endif
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag,
        output cmd_ready,
        output alu_opcode, alu_input1, alu_input2, alu_shiftValue,
        input  alu_result, alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag,
        output rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_tag, op_count,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_req_driver.sv
// Issues one command at a time to an external ALU and returns its result with tag and flags.
// Define ALU_DRV_CHAIN_EN to let cmd_chain feed the previous legal result into alu_input1.
module alu_req_driver (
    input  logic               clk,
    input  logic               rst_n,
    alu_req_driver_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    state_t     state_next;
    logic       opcode_legal;
    logic [7:0] operand_a;

`ifdef ALU_DRV_CHAIN_EN
    logic [7:0] last_result;
`endif

    assign opcode_legal = (bus.cmd_opcode <= 4'd10);

    always_comb begin
        operand_a = bus.cmd_a;
`ifdef ALU_DRV_CHAIN_EN
        if (bus.cmd_chain) begin
            operand_a = last_result;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Illegal opcodes bypass EXEC and answer directly with an error response.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.cmd_valid) state_next = opcode_legal ? EXEC : RESP;
            EXEC: state_next = RESP;
            RESP: if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.alu_opcode     <= '0;
            bus.alu_input1     <= '0;
            bus.alu_input2     <= '0;
            bus.alu_shiftValue <= '0;
            bus.rsp_result     <= '0;
            bus.rsp_flags      <= '0;
            bus.rsp_err        <= 1'b0;
            bus.rsp_tag        <= '0;
            bus.op_count       <= '0;
`ifdef ALU_DRV_CHAIN_EN
            last_result        <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.rsp_tag <= bus.cmd_tag;
                        if (opcode_legal) begin
                            bus.alu_opcode     <= bus.cmd_opcode;
                            bus.alu_input1     <= operand_a;
                            bus.alu_input2     <= bus.cmd_b;
                            bus.alu_shiftValue <= bus.cmd_shamt;
                        end else begin
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_result <= '0;
                            bus.rsp_flags  <= '0;
                        end
                    end
                end
                EXEC: begin
                    bus.rsp_result <= bus.alu_result;
                    bus.rsp_flags  <= {bus.alu_carryFlag, bus.alu_zeroFlag,
                                       bus.alu_overFlowFlag, bus.alu_signFlag};
                    bus.rsp_err    <= 1'b0;
`ifdef ALU_DRV_CHAIN_EN
                    last_result    <= bus.alu_result;
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.op_count <= bus.op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
// Directed bench for alu_req_driver: table of single transactions plus back-pressure,
// reset-in-flight, counter wrap and (with ALU_DRV_CHAIN_EN) chaining sequences.
module tb_alu_req_driver;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_req_driver_if bus ();

    alu_req_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; returns {carry, zero, overflow, sign, result}.
    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic [4:0] sh);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       o;
        w = '0;
        r = '0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            4'd0:  r = a;
            4'd1:  r = b;
            4'd2:  r = a << sh;
            4'd3:  r = a >> sh;
            4'd4:  r = ~a;
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  begin
                r = a - b;
                c = (a < b);
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd8:  r = a ^ b;
            4'd9:  begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                c = w[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd10: begin
                w = {1'b0, a} + 9'd1;
                r = w[7:0];
                c = w[8];
                o = (a == 8'h7F);
            end
            default: r = '0;
        endcase
        return {c, (r == 8'h00), o, r[7], r};
    endfunction

    always_comb begin
        {bus.alu_carryFlag, bus.alu_zeroFlag, bus.alu_overFlowFlag, bus.alu_signFlag,
         bus.alu_result} = alu_model(bus.alu_opcode, bus.alu_input1, bus.alu_input2,
                                     bus.alu_shiftValue);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] sh;
        logic [3:0] tag;
        logic       exp_err;
        logic [7:0] exp_result;
        logic [3:0] exp_flags;
    } vec_t;

    // Bench-side expectation of the held ALU-facing registers and the counter.
    logic [3:0]  e_op;
    logic [7:0]  e_in1;
    logic [7:0]  e_in2;
    logic [4:0]  e_sh;
    logic [15:0] e_cnt;

    task automatic set_chain(input logic v);
`ifdef ALU_DRV_CHAIN_EN
        bus.cmd_chain = v;
`else
        if (v) $display("chain request ignored in this build");
`endif
    endtask

    task automatic run_op(input vec_t v, input logic chain, input logic [7:0] exp_in1);
        int lat;
        @(negedge clk);
        chk("cmd_ready_before", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = v.op;
        bus.cmd_a      = v.a;
        bus.cmd_b      = v.b;
        bus.cmd_shamt  = v.sh;
        bus.cmd_tag    = v.tag;
        set_chain(chain);
        bus.rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        set_chain(1'b0);
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            lat++;
        end
        if (!v.exp_err) begin
            e_op  = v.op;
            e_in1 = exp_in1;
            e_in2 = v.b;
            e_sh  = v.sh;
        end
        chk("latency",       32'(lat), v.exp_err ? 32'd1 : 32'd2);
        chk("rsp_err",       32'(bus.rsp_err), 32'(v.exp_err));
        chk("rsp_result",    32'(bus.rsp_result), 32'(v.exp_result));
        chk("rsp_flags",     32'(bus.rsp_flags), 32'(v.exp_flags));
        chk("rsp_tag",       32'(bus.rsp_tag), 32'(v.tag));
        chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
        chk("alu_opcode",    32'(bus.alu_opcode), 32'(e_op));
        chk("alu_input1",    32'(bus.alu_input1), 32'(e_in1));
        chk("alu_input2",    32'(bus.alu_input2), 32'(e_in2));
        chk("alu_shift",     32'(bus.alu_shiftValue), 32'(e_sh));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        e_cnt = e_cnt + 16'd1;
        @(negedge clk);
        chk("op_count",      32'(bus.op_count), 32'(e_cnt));
        chk("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e_op  = '0;
        e_in1 = '0;
        e_in2 = '0;
        e_sh  = '0;
        e_cnt = '0;
    endtask

    vec_t vecs[11];

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_shamt = '0;
        bus.cmd_tag = '0;
        bus.rsp_ready = 1'b0;
        set_chain(1'b0);

        //        op     a      b      sh    tag    err   result flags{c,z,o,s}
        vecs[0]  = '{4'd9,  8'h7F, 8'h01, 5'd0, 4'h3, 1'b0, 8'h80, 4'b0011};
        vecs[1]  = '{4'd12, 8'h55, 8'h66, 5'd2, 4'h5, 1'b1, 8'h00, 4'b0000};
        vecs[2]  = '{4'd5,  8'hF0, 8'h3C, 5'd0, 4'h1, 1'b0, 8'h30, 4'b0000};
        vecs[3]  = '{4'd9,  8'hFF, 8'h01, 5'd0, 4'h2, 1'b0, 8'h00, 4'b1100};
        vecs[4]  = '{4'd8,  8'hF0, 8'hFF, 5'd0, 4'h4, 1'b0, 8'h0F, 4'b0000};
        vecs[5]  = '{4'd2,  8'h81, 8'h00, 5'd1, 4'h6, 1'b0, 8'h02, 4'b0000};
        vecs[6]  = '{4'd7,  8'h10, 8'h20, 5'd0, 4'h7, 1'b0, 8'hF0, 4'b1001};
        vecs[7]  = '{4'd15, 8'hAA, 8'hBB, 5'd3, 4'hF, 1'b1, 8'h00, 4'b0000};
        vecs[8]  = '{4'd11, 8'h01, 8'h02, 5'd4, 4'h8, 1'b1, 8'h00, 4'b0000};
        vecs[9]  = '{4'd10, 8'hFF, 8'h00, 5'd0, 4'h9, 1'b0, 8'h00, 4'b1100};
        vecs[10] = '{4'd0,  8'h00, 8'h12, 5'd0, 4'hA, 1'b0, 8'h00, 4'b0100};

        repeat (2) @(posedge clk);
        do_reset();
        @(negedge clk);
        chk("rst_cmd_ready",  32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_rsp_flags",  32'(bus.rsp_flags), 32'd0);
        chk("rst_rsp_err",    32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_tag",    32'(bus.rsp_tag), 32'd0);
        chk("rst_op_count",   32'(bus.op_count), 32'd0);
        chk("rst_alu",        {bus.alu_opcode, bus.alu_input1, bus.alu_input2, bus.alu_shiftValue}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], 1'b0, vecs[i].a);
        end

        // Back-pressure: response held five cycles while a second command is offered.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_opcode = 4'd8;
        bus.cmd_a = 8'hF0;
        bus.cmd_b = 8'hFF;
        bus.cmd_shamt = 5'd0;
        bus.cmd_tag = 4'hC;
        @(posedge clk);
        #1;
        bus.cmd_opcode = 4'd6;
        bus.cmd_a = 8'h11;
        bus.cmd_b = 8'h22;
        @(negedge clk);
        chk("bp_exec_valid", 32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_result", 32'(bus.rsp_result), 32'h0F);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("bp_op_count", 32'(bus.op_count), 32'(e_cnt));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        e_cnt = e_cnt + 16'd1;
        @(negedge clk);
        chk("bp_op_count_after", 32'(bus.op_count), 32'(e_cnt));
        chk("bp_no_same_cycle_accept", 32'(bus.cmd_ready), 32'd1);
        chk("bp_alu_opcode_held", 32'(bus.alu_opcode), 32'd8);
        chk("bp_alu_input1_held", 32'(bus.alu_input1), 32'hF0);
        bus.cmd_valid = 1'b0;

        // Reset during EXEC drops the in-flight AND.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_opcode = 4'd5;
        bus.cmd_a = 8'h3C;
        bus.cmd_b = 8'h0F;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rexec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rexec_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        end
        chk("rexec_op_count", 32'(bus.op_count), 32'd0);
        chk("rexec_alu_input1", 32'(bus.alu_input1), 32'd0);

        // Counter wrap: preload near the top, then two handshakes.
        @(negedge clk);
        force bus.op_count = 16'hFFFE;
        @(negedge clk);
        release bus.op_count;
        e_cnt = 16'hFFFE;
        @(negedge clk);
        chk("wrap_preload", 32'(bus.op_count), 32'hFFFE);
        run_op(vecs[8], 1'b0, 8'h00);
        run_op(vecs[7], 1'b0, 8'h00);
        chk("wrap_zero", 32'(bus.op_count), 32'h0000);

`ifdef ALU_DRV_CHAIN_EN
        begin
            vec_t c0;
            vec_t c1;
            c0 = '{4'd9, 8'h10, 8'h20, 5'd0, 4'h1, 1'b0, 8'h30, 4'b0000};
            c1 = '{4'd9, 8'hAA, 8'h05, 5'd0, 4'h2, 1'b0, 8'h35, 4'b0000};
            run_op(c0, 1'b0, 8'h10);
            run_op(c1, 1'b1, 8'h30);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
